// File: rtl/axil_ctrl_regs_pkg.sv
// Shared constants and types for the AXI4-Lite control-register block.
// Covers register offsets, command codes, response codes, FSM states and decode helpers.
package axil_ctrl_regs_pkg;

    localparam int REG_WIDTH = 32;

    localparam logic [REG_WIDTH-1:0] CMD_NOP   = 32'h0000_0000;
    localparam logic [REG_WIDTH-1:0] CMD_WRITE = 32'h0000_0001;
    localparam logic [REG_WIDTH-1:0] CMD_READ  = 32'h0000_0002;

    localparam int unsigned OFF_DATA_IN = 32'h0000_0000;
    localparam int unsigned OFF_ADDRESS = 32'h0000_0004;
    localparam int unsigned OFF_CMD     = 32'h0000_0008;
    localparam int unsigned OFF_STATUS  = 32'h0000_000C;
    localparam int unsigned OFF_DATA_O  = 32'h0000_0010;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    typedef enum logic [2:0] {
        SEL_DATA_IN = 3'd0,
        SEL_ADDRESS = 3'd1,
        SEL_CMD     = 3'd2,
        SEL_STATUS  = 3'd3,
        SEL_DATA_O  = 3'd4,
        SEL_NONE    = 3'd7
    } reg_sel_t;

    function automatic logic is_writable(input reg_sel_t sel);
        return (sel == SEL_DATA_IN) || (sel == SEL_ADDRESS) || (sel == SEL_CMD);
    endfunction

    function automatic logic is_mapped(input reg_sel_t sel);
        return sel != SEL_NONE;
    endfunction

endpackage

// File: rtl/axil_ctrl_regs_if.sv
// AXI4-Lite bus bundle between the host (master) and the control-register block (slave).
interface axil_ctrl_regs_if
    import axil_ctrl_regs_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = REG_WIDTH
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_ctrl_regs.sv
// AXI4-Lite slave holding the data/address/command registers for AXI_top and
// returning its status and output data; independent write and read FSMs.
module axil_ctrl_regs
    import axil_ctrl_regs_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = REG_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    axil_ctrl_regs_if.slave       s_axil,
    output logic [DATA_WIDTH-1:0] data_in_register,
    output logic [DATA_WIDTH-1:0] address_register,
    output logic [DATA_WIDTH-1:0] cmd_register,
    input  logic [DATA_WIDTH-1:0] status_register,
    input  logic [DATA_WIDTH-1:0] data_o_register
);

    localparam int WORD_W = ADDR_WIDTH - 2;
    localparam int STRB_W = DATA_WIDTH / 8;

    localparam logic [WORD_W-1:0] L_W_DATA_IN = WORD_W'(OFF_DATA_IN >> 2);
    localparam logic [WORD_W-1:0] L_W_ADDRESS = WORD_W'(OFF_ADDRESS >> 2);
    localparam logic [WORD_W-1:0] L_W_CMD     = WORD_W'(OFF_CMD >> 2);
    localparam logic [WORD_W-1:0] L_W_STATUS  = WORD_W'(OFF_STATUS >> 2);
    localparam logic [WORD_W-1:0] L_W_DATA_O  = WORD_W'(OFF_DATA_O >> 2);

    wr_state_t             r_wr_state;
    rd_state_t             r_rd_state;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_arready;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_aw_held;
    logic                  r_w_held;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic [DATA_WIDTH-1:0] r_data_in;
    logic [DATA_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0] r_cmd;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_wr_fire;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [STRB_W-1:0]     w_wr_strb;
    reg_sel_t              w_wr_sel;
    reg_sel_t              w_rd_sel;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Only the word index is decoded; the byte lane bits are ignored.
    function automatic reg_sel_t decode_addr(input logic [ADDR_WIDTH-1:0] addr);
        reg_sel_t sel;
        case (addr[ADDR_WIDTH-1:2])
            L_W_DATA_IN: sel = SEL_DATA_IN;
            L_W_ADDRESS: sel = SEL_ADDRESS;
            L_W_CMD:     sel = SEL_CMD;
            L_W_STATUS:  sel = SEL_STATUS;
            L_W_DATA_O:  sel = SEL_DATA_O;
            default:     sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign w_aw_hs = s_axil.awvalid & r_awready;
    assign w_w_hs  = s_axil.wvalid & r_wready;
    assign w_ar_hs = s_axil.arvalid & r_arready;

    // Write commit: fires on the edge where both AW and W are available, either held or arriving now.
    always_comb begin
        w_wr_addr = r_aw_held ? r_awaddr : s_axil.awaddr;
        w_wr_data = r_w_held ? r_wdata : s_axil.wdata;
        w_wr_strb = r_w_held ? r_wstrb : s_axil.wstrb;
        w_wr_fire = (r_wr_state == W_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
        w_wr_sel  = decode_addr(w_wr_addr);
    end

    // Read mux, sampled into rdata on the AR handshake.
    always_comb begin
        w_rd_sel = decode_addr(s_axil.araddr);
        case (w_rd_sel)
            SEL_DATA_IN: w_rd_data = r_data_in;
            SEL_ADDRESS: w_rd_data = r_address;
            SEL_CMD:     w_rd_data = r_cmd;
            SEL_STATUS:  w_rd_data = status_register;
            SEL_DATA_O:  w_rd_data = data_o_register;
            default:     w_rd_data = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Write FSM: captures AW/W independently, then holds the response until bready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_state <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= AXI_RESP_OKAY;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awaddr   <= {ADDR_WIDTH{1'b0}};
            r_wdata    <= {DATA_WIDTH{1'b0}};
            r_wstrb    <= {STRB_W{1'b0}};
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (w_wr_fire) begin
                        r_bresp    <= is_writable(w_wr_sel) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                        r_bvalid   <= 1'b1;
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b0;
                        r_aw_held  <= 1'b0;
                        r_w_held   <= 1'b0;
                        r_wr_state <= W_RESP;
                    end else begin
                        if (w_aw_hs) begin
                            r_aw_held <= 1'b1;
                            r_awaddr  <= s_axil.awaddr;
                        end
                        if (w_w_hs) begin
                            r_w_held <= 1'b1;
                            r_wdata  <= s_axil.wdata;
                            r_wstrb  <= s_axil.wstrb;
                        end
                        r_awready <= !(r_aw_held || w_aw_hs);
                        r_wready  <= !(r_w_held || w_w_hs);
                    end
                end
                W_RESP: begin
                    if (s_axil.bready) begin
                        r_bvalid   <= 1'b0;
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b1;
                        r_wr_state <= W_IDLE;
                    end
                end
                default: begin
                    r_bvalid   <= 1'b0;
                    r_awready  <= 1'b0;
                    r_wready   <= 1'b0;
                    r_wr_state <= W_IDLE;
                end
            endcase
        end
    end

    // Registers driven to AXI_top; unmapped and read-only targets leave them untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_in <= {DATA_WIDTH{1'b0}};
            r_address <= {DATA_WIDTH{1'b0}};
            r_cmd     <= DATA_WIDTH'(CMD_NOP);
        end else if (w_wr_fire) begin
            case (w_wr_sel)
                SEL_DATA_IN: r_data_in <= merge_bytes(r_data_in, w_wr_data, w_wr_strb);
                SEL_ADDRESS: r_address <= merge_bytes(r_address, w_wr_data, w_wr_strb);
                SEL_CMD:     r_cmd     <= merge_bytes(r_cmd, w_wr_data, w_wr_strb);
                default: begin
                    r_data_in <= r_data_in;
                end
            endcase
        end
    end

    // Read FSM: rdata/rresp are frozen from the AR handshake until rready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rresp    <= AXI_RESP_OKAY;
            r_rdata    <= {DATA_WIDTH{1'b0}};
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rdata    <= w_rd_data;
                        r_rresp    <= is_mapped(w_rd_sel) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                        r_rvalid   <= 1'b1;
                        r_arready  <= 1'b0;
                        r_rd_state <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axil.rready) begin
                        r_rvalid   <= 1'b0;
                        r_arready  <= 1'b1;
                        r_rd_state <= R_IDLE;
                    end
                end
                default: begin
                    r_rvalid   <= 1'b0;
                    r_arready  <= 1'b0;
                    r_rd_state <= R_IDLE;
                end
            endcase
        end
    end

    assign s_axil.awready = r_awready;
    assign s_axil.wready  = r_wready;
    assign s_axil.bvalid  = r_bvalid;
    assign s_axil.bresp   = r_bresp;
    assign s_axil.arready = r_arready;
    assign s_axil.rvalid  = r_rvalid;
    assign s_axil.rresp   = r_rresp;
    assign s_axil.rdata   = r_rdata;

    assign data_in_register = r_data_in;
    assign address_register = r_address;
    assign cmd_register     = r_cmd;

endmodule
